// File: rtl/vec_adder_pkg.sv
// vec_adder_pkg: shared precision type, lane constants and lane-LSB mask helper for pipelined_vector_adder
package vec_adder_pkg;
  typedef enum logic [1:0] {PREC8, PREC16, PREC32, PREC_RSV} prec_t;
  localparam int MIN_LANE_W = 8;
  localparam int MAX_W = 1024;
  function automatic int lane_w(prec_t p);
    return p == PREC8 ? 8 : p == PREC16 ? 16 : 32;
  endfunction
  function automatic logic [MAX_W-1:0] lane_lsb_mask(prec_t p, int width);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) m[i] = (i < width) && (i % lane_w(p) == 0);
    return m;
  endfunction
endpackage

// File: rtl/pipelined_vector_adder_segment.sv
// adder_segment: ripple of majority-carry full adders; kill bits restart the chain from lane_cin (a,b,kill,lane_cin,seg_cin -> sum,carry)
module adder_segment #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic [SEG_W-1:0] kill,
  input  logic             lane_cin,
  input  logic             seg_cin,
  output logic [SEG_W-1:0] sum,
  output logic [SEG_W-1:0] carry
);
  logic [SEG_W-1:0] ci;
  for (genvar i = 0; i < SEG_W; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign ci[i] = kill[i] ? lane_cin : seg_cin;
    end else begin : g_up
      assign ci[i] = kill[i] ? lane_cin : carry[i-1];
    end
    assign sum[i]   = a[i] ^ b[i] ^ ci[i];
    assign carry[i] = (a[i] & b[i]) | (a[i] & ci[i]) | (b[i] & ci[i]);
  end
endmodule

// File: rtl/pipelined_vector_adder.sv
// pipelined_vector_adder: STAGES-deep lane-partitioned add/sub; in (in_valid/in_ready, in_a, in_b, in_prec, in_sub, in_cin) -> out (out_valid/out_ready, out_sum, out_cout)
module pipelined_vector_adder
  import vec_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  input  logic [1:0]                  in_prec,
  input  logic                        in_sub,
  input  logic                        in_cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_sum,
  output logic [WIDTH/MIN_LANE_W-1:0] out_cout
);
  localparam int SEG_W = WIDTH / STAGES;
  localparam int NL = WIDTH / MIN_LANE_W;
  typedef struct packed {
    prec_t            prec;
    logic             lcin;
    logic             seg_c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [NL-1:0]    cout;
  } stage_t;
  stage_t src [STAGES];
  stage_t res [STAGES];
  stage_t st_d [STAGES];
  stage_t st_q [STAGES];
  logic [STAGES-1:0] v_d, v_q, src_v, adv;
  logic [SEG_W-1:0] kill [STAGES];
  logic [SEG_W-1:0] seg_sum [STAGES];
  logic [SEG_W-1:0] seg_cy [STAGES];
  if (WIDTH % 32 != 0 || WIDTH % STAGES != 0 || WIDTH > MAX_W) begin : g_bad
    $error("pipelined_vector_adder: WIDTH must be a multiple of 32 and of STAGES");
  end
  always_comb begin
    adv[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = !v_q[k] || adv[k+1];
  end
  always_comb begin
    src[0] = '0;
    src[0].prec = prec_t'(in_prec);
    src[0].lcin = in_sub | in_cin;
    src[0].a = in_a;
    src[0].b = in_b ^ {WIDTH{in_sub}};
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = st_q[k-1];
      src_v[k] = v_q[k-1];
    end
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    assign kill[k] = SEG_W'(lane_lsb_mask(src[k].prec, WIDTH) >> (k * SEG_W));
    adder_segment #(.SEG_W(SEG_W)) u_seg (
      .a       (src[k].a[k*SEG_W +: SEG_W]),
      .b       (src[k].b[k*SEG_W +: SEG_W]),
      .kill    (kill[k]),
      .lane_cin(src[k].lcin),
      .seg_cin (src[k].seg_c),
      .sum     (seg_sum[k]),
      .carry   (seg_cy[k])
    );
  end
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      res[k] = src[k];
      res[k].sum[k*SEG_W +: SEG_W] = seg_sum[k];
      res[k].seg_c = seg_cy[k][SEG_W-1];
      for (int i = 0; i < SEG_W; i++)
        if ((k * SEG_W + i) % MIN_LANE_W == MIN_LANE_W - 1)
          res[k].cout[(k * SEG_W + i) / MIN_LANE_W] = seg_cy[k][i] && ((k * SEG_W + i + 1) % lane_w(src[k].prec) == 0);
    end
  end
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_d[k] = adv[k] ? src_v[k] : v_q[k];
      st_d[k] = (adv[k] && src_v[k]) ? res[k] : st_q[k];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      st_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      st_q <= st_d;
    end
  end
  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign out_sum   = st_q[STAGES-1].sum;
  assign out_cout  = st_q[STAGES-1].cout;
endmodule

// File: tb/tb_pipelined_vector_adder.sv
// tb_pipelined_vector_adder: directed + random scoreboard bench for pipelined_vector_adder
module tb_pipelined_vector_adder;
  localparam int W = 32;
  localparam int S = 4;
  localparam int NL = W / 8;
  typedef struct packed {
    logic [NL-1:0] c;
    logic [W-1:0]  s;
  } res_t;
  logic clk = 0, rst = 1, in_valid = 0, in_sub = 0, in_cin = 0, out_ready = 1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [1:0] in_prec = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_sum;
  logic [NL-1:0] out_cout;
  int total = 0, bad = 0, outs = 0;
  res_t sb[$];
  res_t held, exp_r;
  logic held_v = 0, stall_seen = 0;

  always #5 clk = ~clk;

  pipelined_vector_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_prec(in_prec), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] p,
                                 input logic sub, input logic cin);
    int lw;
    logic [63:0] m, av, bv, r;
    res_t o;
    lw = p == 2'b00 ? 8 : p == 2'b01 ? 16 : 32;
    m = (64'd1 << lw) - 64'd1;
    o = '0;
    for (int l = 0; l < W / lw; l++) begin
      av = (64'(a) >> (l * lw)) & m;
      bv = (64'(b) >> (l * lw)) & m;
      r = sub ? av + (~bv & m) + 64'd1 : av + bv + 64'(cin);
      o.s |= W'((r & m) << (l * lw));
      o.c[(l + 1) * lw / 8 - 1] = r[lw];
    end
    return o;
  endfunction

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      held_v = 0;
    end else begin
      chk("in_ready", in_ready, !(sb.size() == S && !out_ready));
      if (held_v) chk("stall_hold", {out_valid, out_cout, out_sum}, {1'b1, held});
      held_v = out_valid && !out_ready;
      held = {out_cout, out_sum};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          exp_r = sb.pop_front();
          chk("sum", out_sum, exp_r.s);
          chk("cout", out_cout, exp_r.c);
          outs++;
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_prec, in_sub, in_cin));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] p,
                      input logic sub, input logic cin, output int waits);
    in_a = a; in_b = b; in_prec = p; in_sub = sub; in_cin = cin; in_valid = 1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_a = $urandom;
    in_b = $urandom;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  task automatic run_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] p,
                         input logic sub, input logic cin, input logic [W-1:0] es,
                         input logic [NL-1:0] ec, input string tag);
    int w;
    send(a, b, p, sub, cin, w);
    for (int i = 0; i < S; i++) begin
      if (i > 0) tick();
      chk({tag, "_lat"}, out_valid, i == S - 1);
    end
    chk({tag, "_sum"}, out_sum, es);
    chk({tag, "_cout"}, out_cout, ec);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, o0;
    repeat (3) tick();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_in_ready", in_ready, 1);
    run_dir(32'hFF01_7F00, 32'h0101_0100, 2'b00, 0, 0, 32'h0002_8000, 4'b1000, "add8");
    run_dir(32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 0, 0, 32'h0000_0000, 4'b1000, "add32");
    run_dir(32'hFFFF_FFFF, 32'h0000_0001, 2'b01, 0, 0, 32'hFFFF_0000, 4'b0010, "add16");
    run_dir(32'h0505_0505, 32'h0705_0300, 2'b00, 1, 0, 32'hFE00_0205, 4'b0111, "sub8");
    run_dir(32'h0000_0000, 32'h0000_0001, 2'b11, 1, 0, 32'hFFFF_FFFF, 4'b0000, "sub_rsv");
    run_dir(32'h00FF_00FF, 32'h0001_0001, 2'b01, 0, 1, 32'h0101_0101, 4'b0000, "add16_cin");
    o0 = outs;
    fork
      for (int n = 1; n <= 10; n++) send(W'(n), W'(n), 2'b10, 0, 0, w);
      begin
        repeat (3) tick();
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (!in_ready) stall_seen = 1;
          tick();
        end
        out_ready = 1;
      end
    join
    drain("bp");
    chk("bp_stall_seen", stall_seen, 1);
    chk("bp_count", outs - o0, 10);
    o0 = outs;
    out_ready = 0;
    send(32'h0000_0011, 32'h0000_0022, 2'b00, 0, 0, w);
    repeat (2) tick();
    for (int n = 0; n < 3; n++) begin
      send(W'(n * 3 + 7), W'(n), 2'b01, 0, 0, w);
      chk("bubble_wait", w, 0);
    end
    chk("bubble_full_ready", in_ready, 0);
    out_ready = 1;
    drain("bubble");
    chk("bubble_count", outs - o0, 4);
    out_ready = 0;
    o0 = outs;
    send(32'h1111_1111, 32'h2222_2222, 2'b10, 0, 0, w);
    send(32'h3333_3333, 32'h0101_0101, 2'b00, 1, 0, w);
    send(32'h5555_5555, 32'h0F0F_0F0F, 2'b01, 0, 1, w);
    tick();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_in_ready", in_ready, 1);
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < S + 2; i++) begin
      tick();
      chk("rst_flush_valid", out_valid, 0);
    end
    chk("rst_flush_count", outs - o0, 0);
    run_dir(32'h1234_5678, 32'h1111_1111, 2'b10, 0, 0, 32'h2345_6789, 4'b0000, "post_rst");
    fork
      for (int n = 0; n < 40; n++)
        send($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      begin
        repeat (120) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1;
      end
    join
    out_ready = 1;
    drain("rand");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
